// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: data width, saturation value and
// the accumulation controller state encoding.
package fir_pkg;

  localparam int          DW      = 16;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/adder_2x8.sv
// 16-bit adder built from two 8-bit ripple halves; stands beside
// fir_accum_ctrl at FIR top level as a synthesis black-box boundary.
module adder_2x8 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [8:0] w_lo;
  logic [8:0] w_hi;

  assign w_lo = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'd0, cin};
  assign w_hi = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'd0, w_lo[8]};
  assign s    = {w_hi[7:0], w_lo[7:0]};
  assign cout = w_hi[8];

endmodule

// File: rtl/fir_accum_ctrl.sv
// Accumulation stage of the FIR datapath: sums TAPS product words through the
// external adder, saturates on carry-out, and hands each result downstream.
module fir_accum_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] add_a,
  output logic [DW-1:0] add_b,
  output logic          add_cin,
  input  logic [DW-1:0] add_s,
  input  logic          add_cout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_ovf
);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic          r_ovf;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_out_ovf;

  logic          w_in_accum;
  logic          w_accept;
  logic          w_last;
  logic [DW-1:0] w_sum_sat;

  // clr outranks acceptance: a word offered alongside clr is dropped.
  assign w_in_accum = (r_state == ST_ACCUM);
  assign w_accept   = w_in_accum && in_valid && !clr;
  assign w_last     = (r_cnt == CW'(TAPS - 1));
  assign w_sum_sat  = add_cout ? SAT_MAX : add_s;

  assign in_ready  = w_in_accum;
  assign add_a     = r_acc;
  assign add_b     = in_data;
  assign add_cin   = 1'b0;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ovf   = r_out_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_in_accum) begin
        if (clr) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end else if (w_accept) begin
          if (w_last) begin
            r_out_data  <= w_sum_sat;
            r_out_ovf   <= r_ovf | add_cout;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
          end else begin
            r_acc <= w_sum_sat;
            r_ovf <= r_ovf | add_cout;
          end
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
